// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared state encoding, edit-field codes and counter widths for the clock controller
package clock_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;
  localparam int MS_CNT_W = 10;
  localparam int TO_CNT_W = 8;
endpackage

// File: rtl/key_repeat.sv
// key_repeat: rising-edge detect plus delay/period auto-repeat for one direction button
//   i_clk, i_rstn      clock, async active-low reset
//   i_en               repeat allowed (SET state with no state change this cycle)
//   i_tick_ms          1 ms time-base pulse
//   i_btn, i_other     this button and the opposite direction button
//   i_other_rise       opposite button rising this cycle
//   o_rise             raw rising edge of i_btn
//   o_pulse            one-cycle step request (combinational)
module key_repeat
  import clock_ctrl_pkg::*;
#(
  parameter int DELAY  = 500,
  parameter int PERIOD = 100
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  input  logic i_tick_ms,
  input  logic i_btn,
  input  logic i_other,
  input  logic i_other_rise,
  output logic o_rise,
  output logic o_pulse
);
  logic r_prev, r_armed, r_act, r_rep;
  logic [MS_CNT_W-1:0] r_cnt;
  logic w_rise, w_solo, w_hit;
  // r_armed masks the first cycle after reset so a button already held is not an edge
  assign w_rise  = r_armed & i_btn & ~r_prev;
  assign w_solo  = i_btn & ~i_other;
  assign w_hit   = i_en & r_act & w_solo & i_tick_ms &
                   (r_cnt == MS_CNT_W'(r_rep ? PERIOD - 1 : DELAY - 1));
  // a simultaneous rise of both buttons still gives a single step in each direction
  assign o_pulse = (i_en & w_rise & (~i_other | i_other_rise)) | w_hit;
  assign o_rise  = w_rise;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_act   <= 1'b0;
      r_rep   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_prev  <= i_btn;
      r_armed <= 1'b1;
      if (!i_en || !w_solo) begin
        r_act <= 1'b0;
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (w_rise) begin
        r_act <= 1'b1;
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (w_hit) begin
        r_rep <= 1'b1;
        r_cnt <= '0;
      end else if (r_act && i_tick_ms) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set FSM steering time-base and buttons onto hour/min/sec counter controls
//   i_clk, i_rstn                 clock, async active-low reset
//   i_tick_1hz, i_tick_ms         time-base pulses
//   i_btn_mode/up/down            debounced buttons
//   i_sec_carryup, i_min_carryup  counter carries
//   o_{sec,min,hour}_{up,down}    counter step controls
//   o_edit_field, o_editing       field being edited, edit mode flag
module time_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100,
  parameter int TIMEOUT_S        = 10
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_tick_1hz,
  input  logic       i_tick_ms,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_sec_carryup,
  input  logic       i_min_carryup,
  output logic       o_sec_up,
  output logic       o_sec_down,
  output logic       o_min_up,
  output logic       o_min_down,
  output logic       o_hour_up,
  output logic       o_hour_down,
  output logic [1:0] o_edit_field,
  output logic       o_editing
);
  state_e r_state, w_next;
  logic r_mode_prev, r_armed;
  logic [TO_CNT_W-1:0] r_to;
  logic r_sec_up, r_sec_dn, r_min_up, r_min_dn, r_hour_up, r_hour_dn;
  logic w_mode_rise, w_en, w_run, w_act;
  logic w_up_rise, w_dn_rise, w_up_pulse, w_dn_pulse;
  assign w_mode_rise = r_armed & i_btn_mode & ~r_mode_prev;
  assign w_run       = (r_state == ST_RUN);
  // repeat logic runs only while the edit state is stable, so any transition clears it
  assign w_en        = ~w_run & (w_next == r_state);
  assign w_act       = w_up_rise | w_dn_rise | w_up_pulse | w_dn_pulse;
  key_repeat #(.DELAY(REPEAT_DELAY_MS), .PERIOD(REPEAT_PERIOD_MS)) u_up (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(w_en), .i_tick_ms(i_tick_ms),
    .i_btn(i_btn_up), .i_other(i_btn_down), .i_other_rise(w_dn_rise),
    .o_rise(w_up_rise), .o_pulse(w_up_pulse)
  );
  key_repeat #(.DELAY(REPEAT_DELAY_MS), .PERIOD(REPEAT_PERIOD_MS)) u_dn (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(w_en), .i_tick_ms(i_tick_ms),
    .i_btn(i_btn_down), .i_other(i_btn_up), .i_other_rise(w_up_rise),
    .o_rise(w_dn_rise), .o_pulse(w_dn_pulse)
  );
  // mode edge outranks the timeout; SET_SEC + 1 wraps to RUN
  always_comb begin
    w_next = r_state;
    if (w_mode_rise)
      w_next = state_e'(r_state + 2'd1);
    else if (!w_run && i_tick_1hz && r_to == TO_CNT_W'(TIMEOUT_S - 1))
      w_next = ST_RUN;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= ST_RUN;
      r_mode_prev  <= 1'b0;
      r_armed      <= 1'b0;
      r_to         <= '0;
      r_sec_up     <= 1'b0;
      r_sec_dn     <= 1'b0;
      r_min_up     <= 1'b0;
      r_min_dn     <= 1'b0;
      r_hour_up    <= 1'b0;
      r_hour_dn    <= 1'b0;
      o_edit_field <= FIELD_NONE;
      o_editing    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_mode_prev  <= i_btn_mode;
      r_armed      <= 1'b1;
      r_to         <= (!w_en || w_act) ? '0 : r_to + TO_CNT_W'(i_tick_1hz);
      r_sec_up     <= (w_run & i_tick_1hz) | (r_state == ST_SET_SEC & w_up_pulse);
      r_sec_dn     <= r_state == ST_SET_SEC & w_dn_pulse;
      r_min_up     <= r_state == ST_SET_MIN & w_up_pulse;
      r_min_dn     <= r_state == ST_SET_MIN & w_dn_pulse;
      r_hour_up    <= r_state == ST_SET_HOUR & w_up_pulse;
      r_hour_dn    <= r_state == ST_SET_HOUR & w_dn_pulse;
      o_edit_field <= w_next;
      o_editing    <= w_next != ST_RUN;
    end
  end
  // carries ripple straight through in RUN so all three fields step in the same cycle
  assign o_sec_up    = r_sec_up;
  assign o_sec_down  = r_sec_dn;
  assign o_min_up    = r_min_up | (w_run & i_sec_carryup);
  assign o_min_down  = r_min_dn;
  assign o_hour_up   = r_hour_up | (w_run & i_min_carryup);
  assign o_hour_down = r_hour_dn;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed vector table plus corner-case sequences for time_set_ctrl
module tb_time_set_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, t1hz, tms, b_mode, b_up, b_dn, sec59, min59;
  logic sec_carry, min_carry;
  logic o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down, o_editing;
  logic [1:0] o_edit_field;
  logic [5:0] outs;
  assign sec_carry = o_sec_up & sec59;
  assign min_carry = o_min_up & min59;
  assign outs = {o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down};

  time_set_ctrl dut (
    .i_clk(clk), .i_rstn(rstn), .i_tick_1hz(t1hz), .i_tick_ms(tms),
    .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_dn),
    .i_sec_carryup(sec_carry), .i_min_carryup(min_carry),
    .o_sec_up(o_sec_up), .o_sec_down(o_sec_down), .o_min_up(o_min_up),
    .o_min_down(o_min_down), .o_hour_up(o_hour_up), .o_hour_down(o_hour_down),
    .o_edit_field(o_edit_field), .o_editing(o_editing)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; t1hz = 0; tms = 0; b_mode = 0; b_up = 0; b_dn = 0; sec59 = 0; min59 = 0;
    #1;
    chk("reset_outs", {26'd0, outs}, 0);
    chk("reset_field", {29'd0, o_editing, o_edit_field}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic mode_press();
    b_mode = 1'b1; @(posedge clk); #1;
    b_mode = 1'b0; @(posedge clk); #1;
  endtask

  task automatic ms_step(output logic [5:0] a, output logic [5:0] b);
    tms = 1'b1; @(posedge clk); #1; a = outs;
    tms = 1'b0; @(posedge clk); #1; b = outs;
  endtask

  typedef struct {
    logic mode, up, dn, t1;
    logic [5:0] exp_o;
    logic [1:0] exp_f;
    logic exp_e;
  } vec_t;
  vec_t tv[14];

  initial begin
    logic [5:0] a, b;
    int hits[$];
    int extra, cnt;
    rstn = 1'b0;
    // outputs order {sec_up,sec_dn,min_up,min_dn,hour_up,hour_dn}
    tv[0]  = '{0, 0, 0, 0, 6'b000000, 2'd0, 1'b0};
    tv[1]  = '{0, 0, 0, 1, 6'b100000, 2'd0, 1'b0};
    tv[2]  = '{0, 1, 0, 0, 6'b000000, 2'd0, 1'b0};
    tv[3]  = '{1, 0, 0, 0, 6'b000000, 2'd1, 1'b1};
    tv[4]  = '{1, 0, 0, 1, 6'b000000, 2'd1, 1'b1};
    tv[5]  = '{0, 1, 0, 0, 6'b000010, 2'd1, 1'b1};
    tv[6]  = '{0, 0, 1, 0, 6'b000001, 2'd1, 1'b1};
    tv[7]  = '{1, 0, 0, 0, 6'b000000, 2'd2, 1'b1};
    tv[8]  = '{0, 0, 1, 0, 6'b000100, 2'd2, 1'b1};
    tv[9]  = '{0, 1, 1, 0, 6'b000000, 2'd2, 1'b1};
    tv[10] = '{1, 0, 0, 0, 6'b000000, 2'd3, 1'b1};
    tv[11] = '{0, 1, 0, 0, 6'b100000, 2'd3, 1'b1};
    tv[12] = '{1, 0, 0, 0, 6'b000000, 2'd0, 1'b0};
    tv[13] = '{0, 0, 0, 1, 6'b100000, 2'd0, 1'b0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      b_mode = tv[i].mode; b_up = tv[i].up; b_dn = tv[i].dn; t1hz = tv[i].t1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_outs", i), {26'd0, outs}, {26'd0, tv[i].exp_o});
      chk($sformatf("vec%0d_field", i), {29'd0, o_editing, o_edit_field}, {29'd0, tv[i].exp_e, tv[i].exp_f});
    end
    b_mode = 0; b_up = 0; b_dn = 0; t1hz = 0;

    // full rollover: 59:59 carries through in the cycle after the tick
    do_reset();
    sec59 = 1; min59 = 1; t1hz = 1;
    #1;
    chk("carry_before", {29'd0, o_sec_up, o_min_up, o_hour_up}, 0);
    @(posedge clk); #1; t1hz = 0;
    chk("carry_all", {29'd0, o_sec_up, o_min_up, o_hour_up}, 3'b111);
    @(posedge clk); #1;
    chk("carry_after", {29'd0, o_sec_up, o_min_up, o_hour_up}, 0);
    sec59 = 0; min59 = 0;

    // min auto-repeat over a 750 ms hold
    do_reset();
    mode_press(); mode_press();
    chk("rep_field", {30'd0, o_edit_field}, 2);
    b_up = 1; @(posedge clk); #1;
    chk("rep_first", {26'd0, outs}, 6'b001000);
    extra = 0;
    for (int ms = 1; ms <= 750; ms++) begin
      ms_step(a, b);
      if (a == 6'b001000) hits.push_back(ms); else if (a != 0) extra++;
      if (b != 0) extra++;
    end
    b_up = 0;
    chk("rep_count", hits.size(), 3);
    chk("rep_extra", extra, 0);
    if (hits.size() == 3) begin
      chk("rep_t1", hits[0], 500);
      chk("rep_t2", hits[1], 600);
      chk("rep_t3", hits[2], 700);
    end

    // both buttons together in SET_HOUR
    do_reset();
    mode_press();
    b_up = 1; b_dn = 1; @(posedge clk); #1;
    chk("both_pulse", {26'd0, outs}, 6'b000011);
    @(posedge clk); #1;
    chk("both_once", {26'd0, outs}, 0);
    cnt = 0;
    for (int ms = 1; ms <= 2000; ms++) begin
      ms_step(a, b);
      if (a != 0 || b != 0) cnt++;
    end
    chk("both_norep", cnt, 0);
    b_dn = 0;
    cnt = 0;
    for (int ms = 1; ms <= 600; ms++) begin
      ms_step(a, b);
      if (a != 0 || b != 0) cnt++;
    end
    chk("release_one_quiet", cnt, 0);
    chk("both_field", {30'd0, o_edit_field}, 1);
    b_up = 0;

    // edit timeout from SET_SEC
    do_reset();
    mode_press(); mode_press(); mode_press();
    chk("to_field", {30'd0, o_edit_field}, 3);
    cnt = 0;
    for (int s = 1; s <= 10; s++) begin
      if (s == 10) chk("to_still_editing", {31'd0, o_editing}, 1);
      t1hz = 1; @(posedge clk); #1; t1hz = 0;
      if (o_sec_up) cnt++;
      @(posedge clk); #1;
      if (o_sec_up) cnt++;
    end
    chk("to_no_secup", cnt, 0);
    chk("to_exit", {29'd0, o_editing, o_edit_field}, 0);

    // reset while repeating in SET_MIN, up kept held through release
    do_reset();
    mode_press(); mode_press();
    b_up = 1; @(posedge clk); #1;
    for (int ms = 1; ms <= 550; ms++) ms_step(a, b);
    #2 rstn = 1'b0; #1;
    chk("midrst_outs", {26'd0, outs}, 0);
    chk("midrst_field", {29'd0, o_editing, o_edit_field}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    mode_press(); mode_press();
    chk("midrst_setmin", {30'd0, o_edit_field}, 2);
    cnt = 0;
    for (int ms = 1; ms <= 700; ms++) begin
      ms_step(a, b);
      if (a != 0 || b != 0) cnt++;
    end
    chk("midrst_nopulse", cnt, 0);
    b_up = 0;

    // mode held across reset release is not an edge
    rstn = 1'b0; b_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("held_mode_noedge", {29'd0, o_editing, o_edit_field}, 0);
    b_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
